seg7_scan_driver: RTL

//  Downstream display stage for the calculator: consumes the 16-bit display channel
//  (operand A/B, opcode or ALU result) and drives the 8-digit common-anode 7-seg.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/bin_to_bcd_seq.sv | 67 ++++++
 rtl/seg7_scan_driver.sv | 113 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and the segment glyph decoder for the 7-seg scan driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int HEX_DIGITS = 4;
  localparam int DEC_DIGITS = 5;

  // One display digit: a 4-bit code plus a flag that forces the digit dark.
  typedef struct packed {
    logic       blank;
    logic [3:0] code;
  } digit_t;

  localparam digit_t     BLANK   = '{blank: 1'b1, code: 4'h0};
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_LOAD,
    CONV_SHIFT
  } conv_state_t;

  // Active-low {g,f,e,d,c,b,a} glyphs; 'b' and 'd' are lowercase.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one load cycle, then 16 add-3/shift steps.
// done pulses during the final step and bcd carries that step's result
// combinationally, so the consumer can register it on the edge busy falls.
module bin_to_bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  conv_state_t state, state_nxt;
  logic [3:0]  step;
  logic [15:0] bin_q;
  logic [35:0] sr;
  logic [35:0] adj;
  logic [35:0] sr_step;

  // Next-state decode for the conversion sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:  if (start) state_nxt = CONV_LOAD;
      CONV_LOAD:  state_nxt = CONV_SHIFT;
      CONV_SHIFT: if (step == 4'd15) state_nxt = CONV_IDLE;
      default:    state_nxt = CONV_IDLE;
    endcase
  end

  // State register; reset abandons any conversion immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CONV_IDLE;
    else     state <= state_nxt;
  end

  // Step counter, cleared whenever the sequencer is not shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      step <= 4'd0;
    else if (state == CONV_SHIFT) step <= step + 4'd1;
    else                          step <= 4'd0;
  end

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
  always_comb begin
    adj = sr;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (sr[16+4*i +: 4] >= 4'd5) adj[16+4*i +: 4] = sr[16+4*i +: 4] + 4'd3;
    end
    sr_step = adj << 1;
  end

  // Operand latch and working shift register {bcd, bin}
  always_ff @(posedge clk) begin
    if (state == CONV_IDLE && start) bin_q <= bin;
    if (state == CONV_LOAD)          sr <= {20'd0, bin_q};
    else if (state == CONV_SHIFT)    sr <= sr_step;
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_SHIFT) && (step == 4'd15);
  assign bcd  = sr_step[35:16];

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode 7-seg driver: captures a 16-bit value, renders it in hex
// or decimal into digit registers, and time-multiplexes the digits onto an/seg.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        dec_mode,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        busy
);

  localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]           cap_value;
  logic                  cap_mode;
  logic                  capture;
  digit_t                digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shown;
  logic                  conv_busy;
  logic                  conv_done;
  logic [19:0]           conv_bcd;
  logic [CNT_W-1:0]      refresh_cnt;
  logic [2:0]            idx;

  // A change is only taken while idle; changes during a conversion stay
  // visible on the inputs and are picked up by this compare once busy drops.
  assign capture = !conv_busy && ((value != cap_value) || (dec_mode != cap_mode));
  assign busy    = conv_busy;
  assign dp      = 1'b1;

  bin_to_bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (capture && dec_mode),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Remember the value/mode currently shown (or being converted)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_value <= 16'd0;
      cap_mode  <= 1'b0;
    end else if (capture) begin
      cap_value <= value;
      cap_mode  <= dec_mode;
    end
  end

  // Digit registers: hex written at capture, decimal written whole at conversion end.
  // Reset state is the hex rendering of the reset capture (0), so upper digits are dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HEX_DIGITS; i++)          digits[i] <= '0;
      for (int i = HEX_DIGITS; i < NUM_DIGITS; i++) digits[i] <= BLANK;
    end else if (capture && !dec_mode) begin
      for (int i = 0; i < HEX_DIGITS; i++)          digits[i] <= {1'b0, value[4*i +: 4]};
      for (int i = HEX_DIGITS; i < NUM_DIGITS; i++) digits[i] <= BLANK;
    end else if (conv_done) begin
      for (int i = 0; i < DEC_DIGITS; i++)          digits[i] <= {1'b0, conv_bcd[4*i +: 4]};
      for (int i = DEC_DIGITS; i < NUM_DIGITS; i++) digits[i] <= BLANK;
    end
  end

  // Leading-zero suppression, walking down from the top digit; digit 0 always lit
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    shown      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (digits[i].blank || (digits[i].code == 4'h0));
      shown[i]   = !digits[i].blank && !(blank_lz && upper_zero && (i != 0));
    end
  end

  // Refresh timer; the scanned digit advances at terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= 3'd0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      idx         <= idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // Anode and segment registers update together so no digit ghosts into its neighbour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= SEG_OFF;
    end else if (shown[idx]) begin
      an  <= ~(8'h01 << idx);
      seg <= hex_to_seg(digits[idx].code);
    end else begin
      an  <= 8'hFF;
      seg <= SEG_OFF;
    end
  end

endmodule
